// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed FIR MAC sequencer:
//   - datapath widths (TAPS, DW, CW, IW = log2(TAPS), AW accumulator width)
//   - reset-time coefficient bank contents
//   - FSM state type
//   - output saturation helper (accumulator -> output sample)
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int TAPS = 4;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int IW   = $clog2(TAPS);
  localparam int AW   = DW + CW + IW;

  // Coefficients loaded into the bank on reset (tap 0 first).
  localparam logic [CW-1:0] DEF_COEF [TAPS] = '{8'h19, 8'h33, 8'h66, 8'h33};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  // Output is the upper byte of the 16-bit product range; any carry into
  // the guard bits above it means the true value does not fit, so clamp.
  function automatic logic [DW-1:0] fir_saturate(input logic [AW-1:0] acc);
    logic [DW-1:0] res;
    if (acc[AW-1:DW+CW] == {IW{1'b0}}) begin
      res = acc[DW+CW-1:CW];
    end else begin
      res = {DW{1'b1}};
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// ---------------------------------------------------------------------------
// fir_coef_bank
// TAPS x CW coefficient register file. Resets asynchronously to the package
// default coefficients. One synchronous write port, one combinational read
// port addressed by the MAC tap index.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_we, i_waddr,      write strobe / index / value (caller gates legality)
//   i_wdata
//   i_raddr, o_rdata    combinational read
// ---------------------------------------------------------------------------
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [CW-1:0] i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [CW-1:0] o_rdata
);

  logic [CW-1:0] r_coef [TAPS];

  // Coefficient storage: defaults on reset, single write port otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= DEF_COEF[i];
      end
    end else if (i_we) begin
      r_coef[i_waddr] <= i_wdata;
    end else begin
      r_coef <= r_coef;
    end
  end

  assign o_rdata = r_coef[i_raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer
// Time-multiplexed FIR filter: one multiplier/accumulator shared across TAPS
// taps, one tap per clock. IDLE accepts a sample (and/or a coefficient
// write), MAC accumulates TAPS products, OUT presents the saturated result
// until the consumer takes it.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   s_valid, s_ready, s_data       input sample stream
//   m_valid, m_ready, m_data       output sample stream
//   cfg_we, cfg_addr, cfg_data     coefficient write
//   cfg_ready                      write accepted this cycle (IDLE only)
//   cfg_drop                       pulse: write attempted while not ready
//   busy                           FSM is not IDLE
// Widths are taken from fir_pkg.
// ---------------------------------------------------------------------------
module fir_mac_sequencer
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_ready,
  output logic          cfg_drop,
  output logic          busy
);

  fir_state_e       r_state;
  fir_state_e       w_state_nxt;
  logic [DW-1:0]    r_x [TAPS];
  logic [AW-1:0]    r_acc;
  logic [IW-1:0]    r_idx;
  logic [DW-1:0]    r_m_data;
  logic             r_m_valid;
  logic             r_s_ready;
  logic             r_cfg_ready;
  logic             r_cfg_drop;
  logic             r_busy;

  logic             w_accept;
  logic             w_cfg_wr;
  logic             w_last_tap;
  logic [CW-1:0]    w_coef;
  logic [CW+DW-1:0] w_prod;
  logic [AW-1:0]    w_acc_sum;

  // Handshake qualifiers; the ready flags mirror "state is IDLE".
  assign w_accept   = (r_state == ST_IDLE) && s_valid;
  assign w_cfg_wr   = cfg_we && r_cfg_ready;
  assign w_last_tap = (r_idx == IW'(TAPS - 1));

  fir_coef_bank u_coef_bank (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_cfg_wr),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (r_idx),
    .o_rdata (w_coef)
  );

  // One tap product per cycle; guard bits keep the running sum from wrapping.
  assign w_prod    = w_coef * r_x[r_idx];
  assign w_acc_sum = r_acc + AW'(w_prod);

  // Next-state decode for the IDLE -> MAC -> OUT sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (s_valid) begin
          w_state_nxt = ST_MAC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (w_last_tap) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_state_nxt = ST_MAC;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus flag outputs registered from the next state so they
  // are glitch-free and line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_s_ready   <= 1'b1;
      r_cfg_ready <= 1'b1;
      r_m_valid   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s_ready   <= (w_state_nxt == ST_IDLE);
      r_cfg_ready <= (w_state_nxt == ST_IDLE);
      r_m_valid   <= (w_state_nxt == ST_OUT);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Rejected coefficient write: one pulse per cycle the write was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_drop <= 1'b0;
    end else begin
      r_cfg_drop <= cfg_we && !r_cfg_ready;
    end
  end

  // Delay line shifts only when a sample is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= {DW{1'b0}};
      end
    end else if (w_accept) begin
      r_x[0] <= s_data;
      for (int i = 1; i < TAPS; i++) begin
        r_x[i] <= r_x[i-1];
      end
    end else begin
      r_x <= r_x;
    end
  end

  // Accumulator and tap index: cleared on accept, stepped once per MAC cycle.
  // TAPS is a power of two, so the index wraps back to zero by itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {AW{1'b0}};
      r_idx <= {IW{1'b0}};
    end else if (w_accept) begin
      r_acc <= {AW{1'b0}};
      r_idx <= {IW{1'b0}};
    end else if (r_state == ST_MAC) begin
      r_acc <= w_acc_sum;
      r_idx <= r_idx + IW'(1'b1);
    end else begin
      r_acc <= r_acc;
      r_idx <= r_idx;
    end
  end

  // Result capture on the final tap; held through OUT and beyond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data <= {DW{1'b0}};
    end else if ((r_state == ST_MAC) && w_last_tap) begin
      r_m_data <= fir_saturate(w_acc_sum);
    end else begin
      r_m_data <= r_m_data;
    end
  end

  assign s_ready   = r_s_ready;
  assign cfg_ready = r_cfg_ready;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign cfg_drop  = r_cfg_drop;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_sequencer
// Directed scenarios with known results, followed by randomized traffic
// checked against an arithmetic FIR reference (sum of h[i]*x[i], clamp).
// ---------------------------------------------------------------------------
module tb_fir_mac_sequencer;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       cfg_drop;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int model_h [4];
  int model_x [4];

  fir_mac_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_drop  (cfg_drop),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    model_h[0] = 32'h19; model_h[1] = 32'h33; model_h[2] = 32'h66; model_h[3] = 32'h33;
    for (int i = 0; i < 4; i++) model_x[i] = 0;
  endtask

  // Push one sample into the reference and return the expected output.
  task automatic model_sample(input int d, output logic [7:0] exp);
    int sum;
    for (int i = 3; i > 0; i--) model_x[i] = model_x[i-1];
    model_x[0] = d;
    sum = 0;
    for (int i = 0; i < 4; i++) sum += model_h[i] * model_x[i];
    if (sum > 32'hFFFF) exp = 8'hFF;
    else exp = 8'((sum >> 8) & 32'hFF);
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_data = 8'h00; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00;
    m_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // Send one sample (optionally with a same-cycle coefficient write), hold
  // m_ready low for 'hold' cycles once the result is up, then complete it.
  task automatic drive_sample(input logic [7:0] d, input logic we, input logic [1:0] a,
                              input logic [7:0] c, input int hold,
                              output int lat, output logic [7:0] data,
                              output logic [7:0] data_end, output logic to);
    int w;
    to = 1'b0;
    lat = 0;
    s_valid = 1'b1; s_data = d;
    cfg_we = we; cfg_addr = a; cfg_data = c;
    m_ready = (hold == 0);
    w = 0;
    while (s_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 20) to = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0; cfg_we = 1'b0;
    while (m_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 20) to = 1'b1;
    data = m_data;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    data_end = m_data;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cfg_drop !== 1'b0) begin errors++; $display("FAIL reset_cfg_drop got %b want 0", cfg_drop); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
  endtask

  task automatic test_defaults();
    int lat; logic [7:0] d, de; logic to;
    do_reset();
    drive_sample(8'h10, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL defaults_timeout got %b want 0", to); end
    checks++; if (lat != 4) begin errors++; $display("FAIL defaults_latency got %0d want 4", lat); end
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL defaults_first got %h want 01", d); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL defaults_m_valid_drop got %b want 0", m_valid); end
    drive_sample(8'h10, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL defaults_second got %h want 04", d); end
  endtask

  task automatic test_impulse();
    int lat; logic [7:0] d, de; logic to;
    logic [7:0] ins  [5];
    logic [7:0] outs [5];
    ins  = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    outs = '{8'h0C, 8'h19, 8'h33, 8'h19, 8'h00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_sample(ins[i], 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
      checks++;
      if (d !== outs[i] || to !== 1'b0)
        begin errors++; $display("FAIL impulse_%0d got %h want %h (timeout %b)", i, d, outs[i], to); end
    end
  endtask

  task automatic test_steady_max();
    int lat; logic [7:0] d, de; logic to;
    do_reset();
    for (int i = 0; i < 4; i++) drive_sample(8'hFF, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    checks++; if (d !== 8'hE4) begin errors++; $display("FAIL steady_max got %h want e4", d); end
  endtask

  task automatic test_saturation();
    int lat; logic [7:0] d, de; logic to;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = 8'hFF;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      checks++; if (cfg_drop !== 1'b0) begin errors++; $display("FAIL sat_cfg_drop_%0d got %b want 0", a, cfg_drop); end
    end
    drive_sample(8'hFF, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    checks++; if (d !== 8'hFE) begin errors++; $display("FAIL sat_first got %h want fe", d); end
    for (int i = 0; i < 3; i++) drive_sample(8'hFF, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL sat_fourth got %h want ff", d); end
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] d, de; logic to;
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h10;
    @(posedge clk); #1;
    s_data = 8'h80;  // stays valid but must be ignored until IDLE
    lat = 0;
    while (m_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h01 || s_ready !== 1'b0 || busy !== 1'b1)
        begin errors++; $display("FAIL bp_hold_%0d got v=%b d=%h r=%b b=%b want v=1 d=01 r=0 b=1",
                                 i, m_valid, m_data, s_ready, busy); end
      @(posedge clk); #1;
    end
    m_ready = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release got v=%b b=%b r=%b want v=0 b=0 r=1", m_valid, busy, s_ready); end
    drive_sample(8'h00, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL bp_ignored_input got %h want 03", d); end
  endtask

  task automatic test_cfg_protect();
    int lat; logic [7:0] d, de; logic to;
    do_reset();
    drive_sample(8'h80, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    drive_sample(8'h00, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    s_valid = 1'b1; s_data = 8'h00;
    @(posedge clk); #1;
    s_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 8'h00;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checks++; if (cfg_drop !== 1'b1) begin errors++; $display("FAIL cfgp_drop_pulse got %b want 1", cfg_drop); end
    @(posedge clk); #1;
    checks++; if (cfg_drop !== 1'b0) begin errors++; $display("FAIL cfgp_drop_end got %b want 0", cfg_drop); end
    lat = 2;
    while (m_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (m_data !== 8'h33 || lat != 4)
      begin errors++; $display("FAIL cfgp_result got %h lat %0d want 33 lat 4", m_data, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_same_cycle_cfg();
    int lat; logic [7:0] d, de; logic to;
    do_reset();
    drive_sample(8'h80, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    drive_sample(8'h00, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    drive_sample(8'h00, 1'b1, 2'd2, 8'h00, 0, lat, d, de, to);
    checks++; if (cfg_drop !== 1'b0) begin errors++; $display("FAIL same_cfg_drop got %b want 0", cfg_drop); end
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL same_cfg_result got %h want 00", d); end
  endtask

  task automatic test_reset_mid_mac();
    int lat; logic [7:0] d, de; logic to;
    do_reset();
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h00;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    s_valid = 1'b1; s_data = 8'h10;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs got v=%b b=%b want v=0 b=0", m_valid, busy); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    drive_sample(8'h10, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    checks++; if (d !== 8'h01 || lat != 4)
      begin errors++; $display("FAIL midrst_first got %h lat %0d want 01 lat 4", d, lat); end
    drive_sample(8'h10, 1'b0, 2'd0, 8'h00, 0, lat, d, de, to);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL midrst_second got %h want 04", d); end
  endtask

  task automatic test_random();
    int lat; logic [7:0] d, de, exp; logic to;
    logic [7:0] sd, cd; logic [1:0] ca; logic we; int hold; int kind;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      ca = 2'($urandom_range(0, 3));
      cd = 8'($urandom_range(0, 255));
      if (kind == 0) begin
        cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_h[ca] = int'(cd);
        checks++; if (cfg_drop !== 1'b0) begin errors++; $display("FAIL rand_cfg_drop_%0d got %b want 0", n, cfg_drop); end
      end else begin
        sd = 8'($urandom_range(0, 255));
        we = (kind == 1);
        hold = $urandom_range(0, 3);
        if (we) model_h[ca] = int'(cd);
        model_sample(int'(sd), exp);
        drive_sample(sd, we, ca, cd, hold, lat, d, de, to);
        checks++;
        if (d !== exp || de !== exp || lat != 4 || to !== 1'b0)
          begin errors++; $display("FAIL rand_sample_%0d got %h/%h lat %0d want %h lat 4", n, d, de, lat, exp); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00;
    model_reset();
    test_reset();
    test_defaults();
    test_impulse();
    test_steady_max();
    test_saturation();
    test_backpressure();
    test_cfg_protect();
    test_same_cycle_cfg();
    test_reset_mid_mac();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR controller. It shares one 8x8 multiplier/accumulator across TAPS coefficient taps, one tap per clock. It accepts samples over a valid/ready stream, owns a runtime-writable coefficient bank, and emits one filtered sample per input over a valid/ready stream. It sits between the sample source and downstream consumer and replaces a fully parallel 4-tap pipeline where area matters more than throughput.

Parameters:
TAPS, 4, number of filter taps; power of two, minimum 2
DW, 8, sample width (unsigned)
CW, 8, coefficient width (unsigned)
AW, DW+CW+log2(TAPS) = 18, accumulator width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_data  in  DW  input sample
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts output
m_data  out  DW  filtered output sample
cfg_we  in  1  coefficient write strobe
cfg_addr  in  log2(TAPS)  coefficient index
cfg_data  in  CW  coefficient value
cfg_ready  out  1  coefficient write will be accepted this cycle
cfg_drop  out  1  one-cycle pulse: a write was attempted while cfg_ready=0
busy  out  1  state is not IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; delay line x[0..TAPS-1]=0; acc=0; tap index=0; m_valid=0; m_data=0; cfg_drop=0.
- Reset coefficients: h[0..3]=8'h19, 8'h33, 8'h66, 8'h33 (constants from the shared package).
- Reset applied mid-operation aborts the sample in flight. There is no partial output.
- FSM states: IDLE, MAC, OUT.
- IDLE: s_ready=1, cfg_ready=1.
  - On s_valid at edge k: x[0]<=s_data; x[i]<=x[i-1]; acc<=0; idx<=0; go to MAC.
- MAC: s_ready=0, cfg_ready=0.
  - Each edge: acc<=acc+h[idx]*x[idx]; idx<=idx+1.
  - On the edge with idx==TAPS-1: go to OUT. The accumulation happens on edges k+1..k+TAPS.
- OUT: m_valid=1; m_data is registered and stable. s_ready=0, cfg_ready=0.
  - On m_ready: go to IDLE; m_valid deasserts on the next edge.
- Latency: m_valid rises after edge k+TAPS, i.e. TAPS cycles after acceptance. Throughput is at most one sample per TAPS+2 cycles.
- m_data: acc[15:8] if acc[AW-1:16]==0, else 8'hFF (saturate). Products are unsigned CW+DW bits; the accumulator never wraps.
- Backpressure: m_valid and m_data hold unchanged while m_ready=0. No input is accepted while a result is pending.
- Coefficient writes are accepted only when cfg_ready=1. The write takes effect at that edge.
- Simultaneous cfg_we and s_valid in IDLE: both are accepted. The new coefficient is used for that sample.
- cfg_we with cfg_ready=0: the write is discarded, cfg_drop pulses for one cycle, and the bank is unchanged.
- m_ready asserted while m_valid=0: ignored.

Decomposition:
- Package fir_pkg:
  - DW, CW, TAPS defaults
  - default coefficient array
  - state enum {IDLE, MAC, OUT}
  - saturation helper function
- Sub-module fir_coef_bank: TAPS x CW register file.
  - Asynchronous reset to the package defaults.
  - One write port; combinational read by idx.
- The FSM, delay line and MAC stay in fir_mac_sequencer.

Test Plan:
- Reset defaults: after reset, send x=0x10 with m_ready=1 -> m_valid exactly 4 cycles after acceptance, m_data=0x01. A second x=0x10 -> m_data=0x04.
- Impulse response: send 0x80 then 0x00, 0x00, 0x00 -> m_data sequence 0x0C, 0x19, 0x33, 0x19. Then 0x00 -> m_data=0x00.
- Steady maximum: four samples of 0xFF -> fourth m_data=0xE4.
- Saturation: write all coefficients 0xFF in IDLE, then four samples of 0xFF -> fourth m_data=0xFF.
- Backpressure: hold m_ready=0 for 5 cycles while in OUT -> m_valid stays 1, m_data stable, s_ready=0, s_valid ignored. Release -> IDLE next cycle.
- Config protection: cfg_we to addr 2, value 0x00, during MAC -> cfg_drop pulses once and the result uses 0x66.
- Same-cycle config: the same write issued together with s_valid in IDLE is applied to that sample.
- Reset mid-MAC: assert rst_n=0 during MAC -> m_valid=0, busy=0, coefficients back to defaults, the next result matches the first scenario.
